// File: rtl/tc_core_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tc_core_stream
//  Description : Tile engine computing D = A*B (+C) one row at a time with N
//                parallel MAC lanes; D rows stream out over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module tc_core_stream #(
    parameter int M       = 16,
    parameter int N       = 16,
    parameter int K       = 16,
    parameter int DW_DATA = 16,
    parameter int DW_IDX  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_en,
    input  logic                    compute_en,
    input  logic                    acc_mode,
    input  logic                    wb_c,
    input  logic                    write_a,
    input  logic [K*DW_DATA-1:0]    A_input,
    input  logic [DW_IDX-1:0]       A_row,
    input  logic                    write_b,
    input  logic [N*DW_DATA-1:0]    B_input,
    input  logic [DW_IDX-1:0]       B_row,
    input  logic                    write_c,
    input  logic [N*DW_DATA-1:0]    C_input,
    input  logic [DW_IDX-1:0]       C_row,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*DW_DATA-1:0]    D_row_out,
    output logic [DW_IDX-1:0]       D_row_idx,
    output logic                    done
);

    localparam int c_acc_w = 2*DW_DATA + $clog2(K+1);
    localparam int c_kw    = (K > 1) ? $clog2(K) : 1;
    localparam int c_ext_w = c_acc_w - 2*DW_DATA;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_compute = 2'd1;
    localparam logic [1:0] c_st_out     = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

    logic [DW_DATA-1:0] r_a_mem [M][K];
    logic [DW_DATA-1:0] r_b_mem [K][N];
    logic [DW_DATA-1:0] r_c_mem [M][N];

    logic [1:0]                 r_state;
    logic [DW_IDX-1:0]          r_i;
    logic [c_kw-1:0]            r_k;
    logic                       r_acc_mode;
    logic                       r_wb_c;
    logic                       r_busy;
    logic                       r_out_valid;
    logic                       r_done;
    logic [N*DW_DATA-1:0]       r_d_row;
    logic [DW_IDX-1:0]          r_d_idx;
    logic signed [c_acc_w-1:0]  r_acc [N];

    logic signed [c_acc_w-1:0]  w_acc_next   [N];
    logic signed [c_acc_w-1:0]  w_init_start [N];
    logic signed [c_acc_w-1:0]  w_init_next  [N];
    logic [N*DW_DATA-1:0]       w_d_next;
    logic [DW_DATA-1:0]         w_a_elem;
    logic [DW_IDX-1:0]          w_i_next;
    logic                       w_load;
    logic                       w_hs;
    logic                       w_last_row;

    // Buffer loads are only honoured while the engine is idle.
    assign w_load     = load_en && (r_state == c_st_idle) && !reset;
    assign w_hs       = (r_state == c_st_out) && out_ready && !reset;
    assign w_last_row = (r_i == DW_IDX'(M-1));
    assign w_i_next   = w_last_row ? '0 : r_i + 1'b1;
    assign w_a_elem   = r_a_mem[r_i][r_k];

    generate
        for (genvar j = 0; j < N; j++) begin : g_lane
            logic signed [2*DW_DATA-1:0] w_prod;
            logic [DW_DATA-1:0]          w_c_first;
            logic [DW_DATA-1:0]          w_c_follow;

            assign w_prod        = $signed(w_a_elem) * $signed(r_b_mem[r_k][j]);
            assign w_acc_next[j] = r_acc[j] + {{c_ext_w{w_prod[2*DW_DATA-1]}}, w_prod};

            // A C row 0 write landing on the start edge is forwarded into the seed.
            assign w_c_first = (w_load && write_c && (C_row == '0)) ?
                               C_input[j*DW_DATA +: DW_DATA] : r_c_mem[0][j];
            assign w_c_follow = r_c_mem[w_i_next][j];

            assign w_init_start[j] = acc_mode ? '0 :
                {{(c_acc_w-DW_DATA){w_c_first[DW_DATA-1]}}, w_c_first};
            assign w_init_next[j]  = r_acc_mode ? '0 :
                {{(c_acc_w-DW_DATA){w_c_follow[DW_DATA-1]}}, w_c_follow};

            assign w_d_next[j*DW_DATA +: DW_DATA] = w_acc_next[j][DW_DATA-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_load && write_a && (int'(A_row) < M)) begin
            for (int j = 0; j < K; j++)
                r_a_mem[A_row][j] <= A_input[j*DW_DATA +: DW_DATA];
        end
        if (w_load && write_b && (int'(B_row) < K)) begin
            for (int j = 0; j < N; j++)
                r_b_mem[B_row][j] <= B_input[j*DW_DATA +: DW_DATA];
        end
        if (w_load && write_c && (int'(C_row) < M)) begin
            for (int j = 0; j < N; j++)
                r_c_mem[C_row][j] <= C_input[j*DW_DATA +: DW_DATA];
        end else if (w_hs && r_wb_c) begin
            for (int j = 0; j < N; j++)
                r_c_mem[r_i][j] <= r_d_row[j*DW_DATA +: DW_DATA];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_i         <= '0;
            r_k         <= '0;
            r_acc_mode  <= 1'b0;
            r_wb_c      <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_d_row     <= '0;
            r_d_idx     <= '0;
            for (int j = 0; j < N; j++) r_acc[j] <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_done <= 1'b0;
                    if (compute_en) begin
                        r_state    <= c_st_compute;
                        r_busy     <= 1'b1;
                        r_acc_mode <= acc_mode;
                        r_wb_c     <= wb_c;
                        r_i        <= '0;
                        r_k        <= '0;
                        r_acc      <= w_init_start;
                    end
                end
                c_st_compute: begin
                    r_acc <= w_acc_next;
                    if (r_k == c_kw'(K-1)) begin
                        r_state     <= c_st_out;
                        r_out_valid <= 1'b1;
                        r_d_row     <= w_d_next;
                        r_d_idx     <= r_i;
                        r_k         <= '0;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                c_st_out: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_last_row) begin
                            r_state <= c_st_done;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_st_compute;
                            r_i     <= w_i_next;
                            r_k     <= '0;
                            r_acc   <= w_init_next;
                        end
                    end
                end
                c_st_done: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign D_row_out = r_d_row;
    assign D_row_idx = r_d_idx;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tc_core_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tc_core_stream
//  Description : Directed bench for tc_core_stream with hand-computed rows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tc_core_stream;

    localparam int M  = 16;
    localparam int N  = 16;
    localparam int K  = 16;
    localparam int DW = 16;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            load_en, compute_en, acc_mode, wb_c;
    logic            write_a, write_b, write_c;
    logic [K*DW-1:0] A_input;
    logic [N*DW-1:0] B_input, C_input;
    logic [IW-1:0]   A_row, B_row, C_row;
    logic            busy, out_valid, out_ready, done;
    logic [N*DW-1:0] D_row_out;
    logic [IW-1:0]   D_row_idx;

    tc_core_stream #(.M(M), .N(N), .K(K), .DW_DATA(DW), .DW_IDX(IW)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .compute_en(compute_en),
        .acc_mode(acc_mode), .wb_c(wb_c),
        .write_a(write_a), .A_input(A_input), .A_row(A_row),
        .write_b(write_b), .B_input(B_input), .B_row(B_row),
        .write_c(write_c), .C_input(C_input), .C_row(C_row),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .D_row_out(D_row_out), .D_row_idx(D_row_idx), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ta    [M][K];
    logic [DW-1:0] tbm   [K][N];
    logic [DW-1:0] tcm   [M][N];
    logic [DW-1:0] exp_d [M][N];

    typedef struct {
        logic [DW-1:0] a_val;
        logic [DW-1:0] b_val;
        bit            b_ident;
        logic [DW-1:0] c_val;
        bit            c_by_row;
        bit            mode;
        logic [DW-1:0] exp_val;
        bit            exp_by_row;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] exp_row(input int i);
        logic [N*DW-1:0] r;
        for (int j = 0; j < N; j++) r[j*DW +: DW] = exp_d[i][j];
        return r;
    endfunction

    task automatic load(input bit la, input bit lb, input bit lc);
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            load_en = 1'b1;
            write_a = la; write_b = lb; write_c = lc;
            A_row = IW'(r); B_row = IW'(r); C_row = IW'(r);
            for (int j = 0; j < K; j++) A_input[j*DW +: DW] = ta[r][j];
            for (int j = 0; j < N; j++) B_input[j*DW +: DW] = tbm[r][j];
            for (int j = 0; j < N; j++) C_input[j*DW +: DW] = tcm[r][j];
        end
        @(negedge clk);
        load_en = 1'b0; write_a = 1'b0; write_b = 1'b0; write_c = 1'b0;
    endtask

    task automatic fill_identity();
        for (int i = 0; i < M; i++)
            for (int k = 0; k < K; k++) ta[i][k] = (i == k) ? 16'd1 : 16'd0;
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++) tbm[k][j] = DW'(16*k + j);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                tcm[i][j]   = '0;
                exp_d[i][j] = DW'(16*i + j);
            end
    endtask

    task automatic run(input string tag, input bit mode, input bit wb, input int stall,
                       input bit timing, input bit disturb);
        int e, rows, dones, hold;
        bit seen_done, stable, seen_valid;
        logic [N*DW-1:0] held_d;
        logic [IW-1:0]   held_i;
        rows = 0; dones = 0; hold = 0; seen_done = 0; stable = 1; seen_valid = 0;
        held_d = '0; held_i = '0;
        @(negedge clk);
        compute_en = 1'b1; acc_mode = mode; wb_c = wb; out_ready = (stall == 0);
        @(negedge clk);
        compute_en = 1'b0;
        e = cyc;
        chk({tag, "_busy_start"}, busy, 1);
        for (int t = 0; t < 4000 && !seen_done; t++) begin
            if (disturb && t == 2) begin
                load_en = 1'b1; write_a = 1'b1; write_b = 1'b1; write_c = 1'b1;
                A_row = '0; B_row = '0; C_row = '0;
                A_input = {K{16'h5555}}; B_input = {N{16'h5555}}; C_input = {N{16'h5555}};
                compute_en = 1'b1;
            end else if (disturb && t == 3) begin
                load_en = 1'b0; write_a = 1'b0; write_b = 1'b0; write_c = 1'b0;
                compute_en = 1'b0;
            end
            if (done) begin
                dones++;
                seen_done = 1;
                if (timing) chk({tag, "_done_cycle"}, cyc, e + M*(K+1));
            end
            if (out_valid) begin
                if (!seen_valid) begin
                    seen_valid = 1;
                    if (timing) chk({tag, "_first_valid_cycle"}, cyc, e + K);
                end
                if (hold == 0) begin
                    held_d = D_row_out; held_i = D_row_idx; stable = 1;
                end else if (D_row_out !== held_d || D_row_idx !== held_i) begin
                    stable = 0;
                end
                if (hold < stall) begin
                    out_ready = 1'b0;
                    hold++;
                end else begin
                    out_ready = 1'b1;
                    chk({tag, "_row_idx"}, D_row_idx, rows);
                    if (rows < M) chk({tag, "_row_data"}, D_row_out, exp_row(rows));
                    if (stall > 0) chk({tag, "_stall_stable"}, stable, 1);
                    rows++;
                    hold = 0;
                end
            end else begin
                out_ready = (stall == 0);
            end
            if (!seen_done) @(negedge clk);
        end
        chk({tag, "_finished"}, seen_done, 1);
        chk({tag, "_handshakes"}, rows, M);
        @(negedge clk);
        chk({tag, "_done_once"}, done, 0);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_dones"}, dones, 1);
    endtask

    initial begin
        reset = 1'b1; load_en = 1'b0; compute_en = 1'b0; acc_mode = 1'b0; wb_c = 1'b0;
        write_a = 1'b0; write_b = 1'b0; write_c = 1'b0;
        A_input = '0; B_input = '0; C_input = '0; A_row = '0; B_row = '0; C_row = '0;
        out_ready = 1'b0;

        // Uniform-fill vectors: row i of D is exp_val (+ i when exp_by_row).
        vt[0] = '{16'h0001, 16'h0002, 0, 16'h0000, 1, 0, 16'h0020, 1};
        vt[1] = '{16'h0001, 16'h0002, 0, 16'h0000, 1, 1, 16'h0020, 0};
        vt[2] = '{16'h7FFF, 16'h0002, 0, 16'h0000, 0, 0, 16'hFFE0, 0};
        vt[3] = '{16'hFFFF, 16'h0000, 1, 16'h0000, 0, 0, 16'hFFFF, 0};
        vt[4] = '{16'hFFFF, 16'hFFFF, 0, 16'h0000, 0, 0, 16'h0010, 0};
        vt[5] = '{16'h0003, 16'h0005, 0, 16'h0100, 0, 0, 16'h01F0, 0};
        vt[6] = '{16'h8000, 16'h8000, 0, 16'hFFFF, 0, 0, 16'hFFFF, 0};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_d_row", D_row_out, 0);
        chk("rst_d_idx", D_row_idx, 0);
        reset = 1'b0;

        fill_identity();
        load(1, 1, 1);
        run("identity", 0, 0, 0, 1, 0);

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < M; i++)
                for (int k = 0; k < K; k++) ta[i][k] = vt[v].a_val;
            for (int k = 0; k < K; k++)
                for (int j = 0; j < N; j++)
                    tbm[k][j] = vt[v].b_ident ? ((k == j) ? 16'd1 : 16'd0) : vt[v].b_val;
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++) begin
                    tcm[i][j]   = vt[v].c_by_row ? DW'(i) : vt[v].c_val;
                    exp_d[i][j] = vt[v].exp_val + (vt[v].exp_by_row ? DW'(i) : DW'(0));
                end
            load(1, 1, 1);
            run($sformatf("vec%0d", v), vt[v].mode, 0, 0, 0, 0);
        end

        fill_identity();
        load(1, 1, 1);
        run("backpressure", 0, 0, 3, 0, 0);

        // K-split: pass 1 writes A1*B1 into C, pass 2 adds A2*B2 on top.
        fill_identity();
        load(1, 1, 1);
        run("ksplit_p1", 0, 1, 0, 0, 0);
        for (int i = 0; i < M; i++)
            for (int k = 0; k < K; k++) ta[i][k] = 16'd1;
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++) tbm[k][j] = 16'd2;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) exp_d[i][j] = DW'(16*i + j + 32);
        load(1, 1, 0);
        run("ksplit_p2", 0, 0, 0, 0, 1);

        // Reset during row 5 compute, then rerun on the untouched buffers.
        fill_identity();
        load(1, 1, 1);
        begin
            int e;
            @(negedge clk);
            compute_en = 1'b1; acc_mode = 1'b0; wb_c = 1'b0; out_ready = 1'b1;
            @(negedge clk);
            compute_en = 1'b0;
            e = cyc;
            while (cyc < e + 5*(K+1) + 5) @(negedge clk);
            chk("midrun_busy", busy, 1);
            reset = 1'b1;
            @(negedge clk);
            chk("midrun_out_valid", out_valid, 0);
            chk("midrun_busy_cleared", busy, 0);
            chk("midrun_done", done, 0);
            chk("midrun_d_row", D_row_out, 0);
            chk("midrun_d_idx", D_row_idx, 0);
            reset = 1'b0;
        end
        run("rerun", 0, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
